// File: rtl/hdr_mode_controller.sv
// rtl/hdr_mode_controller.sv - target-side SDR/HDR-DDR mode sequencer
//
// Decides which engine (SDR or HDR-DDR) owns the bus, re-arms the DDR engine
// on HDR entry and on every HDR restart, and returns the target to SDR after
// an HDR exit pattern followed by a STOP, or after a bus-idle timeout.
//
// Optional feature macro: HDR_FRAME_COUNT_EN (restart counter on o_frame_cnt).
//
// Ports:
//   i_sys_clk      system clock, rising edge
//   i_sys_rst      asynchronous active-low reset
//   i_scl, i_sda   bus lines, already sampled into i_sys_clk
//   i_enthdr_ddr   ENTHDR0 CCC received (1-cycle pulse)
//   i_restart_det  HDR restart pattern seen (1-cycle pulse)
//   i_exit_det     HDR exit pattern seen (1-cycle pulse)
//   i_ddr_error    DDR framing/parity error
//   o_sdr_en       SDR engine enable
//   o_ddr_en       DDR engine enable
//   o_mode         0 SDR, 1 HDR_ENTRY, 2 HDR_ACTIVE/RESTART, 3 HDR_ERROR/EXIT
//   o_ddr_rearm    1-cycle pulse: DDR engine resets its frame state
//   o_hdr_exit     1-cycle pulse on return to SDR
//   o_timeout      sticky idle-timeout flag, cleared by the next ENTHDR0
//   o_frame_cnt    restarts in the current HDR session (0 when feature off)

module hdr_mode_controller #(
   parameter int ENTRY_DLY    = 4,
   parameter int IDLE_TIMEOUT = 1024,
   parameter int CNT_W        = 11
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   input  logic       i_enthdr_ddr,
   input  logic       i_restart_det,
   input  logic       i_exit_det,
   input  logic       i_ddr_error,
   output logic       o_sdr_en,
   output logic       o_ddr_en,
   output logic [1:0] o_mode,
   output logic       o_ddr_rearm,
   output logic       o_hdr_exit,
   output logic       o_timeout,
   output logic [7:0] o_frame_cnt
);

   typedef enum logic [2:0] {
      ST_SDR     = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_ACTIVE  = 3'd2,
      ST_RESTART = 3'd3,
      ST_ERROR   = 3'd4,
      ST_EXIT    = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LP_IDLE_MAX  = CNT_W'(IDLE_TIMEOUT);
   localparam logic [3:0]       LP_ENTRY_LD  = 4'(ENTRY_DLY - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_entry_cnt;
   logic [3:0]       w_entry_cnt_nxt;
   logic             r_scl_q;
   logic             r_sda_q;
   logic [CNT_W-1:0] r_idle_cnt;
   logic             w_scl_edge;
   logic             w_stop;
   logic             w_idle_to;

   logic             r_sdr_en;
   logic             r_ddr_en;
   logic [1:0]       r_mode;
   logic             r_ddr_rearm;
   logic             r_hdr_exit;
   logic             r_timeout;

   logic             w_sdr_en;
   logic             w_ddr_en;
   logic [1:0]       w_mode;
   logic             w_ddr_rearm;
   logic             w_hdr_exit;
   logic             w_timeout;

   assign w_scl_edge = i_scl ^ r_scl_q;
   // STOP: SDA rises while SCL has been high for two samples
   assign w_stop     = i_scl & r_scl_q & i_sda & ~r_sda_q;
   assign w_idle_to  = (r_idle_cnt == LP_IDLE_MAX);

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         r_scl_q <= 1'b1;
         r_sda_q <= 1'b1;
      end else begin
         r_scl_q <= i_scl;
         r_sda_q <= i_sda;
      end
   end

   // Any bus activity or any state change restarts the idle window
   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         r_idle_cnt <= '0;
      end else if (w_scl_edge || (w_next_state != r_state)) begin
         r_idle_cnt <= '0;
      end else if (!w_idle_to) begin
         r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         r_state     <= ST_SDR;
         r_entry_cnt <= 4'd0;
      end else begin
         r_state     <= w_next_state;
         r_entry_cnt <= w_entry_cnt_nxt;
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_entry_cnt_nxt = r_entry_cnt;
      w_ddr_rearm     = 1'b0;
      w_hdr_exit      = 1'b0;
      w_timeout       = r_timeout;
      case (r_state)
         ST_SDR: begin
            if (i_enthdr_ddr) begin
               w_next_state    = ST_ENTRY;
               w_entry_cnt_nxt = LP_ENTRY_LD;
               w_timeout       = 1'b0;
            end
         end
         ST_ENTRY: begin
            if (i_exit_det) begin
               w_next_state = ST_EXIT;
            end else if (r_entry_cnt == 4'd0) begin
               w_next_state = ST_ACTIVE;
               w_ddr_rearm  = 1'b1;
            end else begin
               w_entry_cnt_nxt = r_entry_cnt - 4'd1;
            end
         end
         ST_ACTIVE: begin
            if (i_exit_det) begin
               w_next_state = ST_EXIT;
            end else if (i_ddr_error) begin
               w_next_state = ST_ERROR;
            end else if (i_restart_det) begin
               w_next_state = ST_RESTART;
               w_ddr_rearm  = 1'b1;
            end else if (w_idle_to) begin
               w_next_state = ST_SDR;
               w_timeout    = 1'b1;
               w_hdr_exit   = 1'b1;
            end
         end
         ST_RESTART: begin
            // a back-to-back restart pulse is intentionally dropped
            w_next_state = ST_ACTIVE;
         end
         ST_ERROR: begin
            if (i_exit_det) begin
               w_next_state = ST_EXIT;
            end else if (w_idle_to) begin
               w_next_state = ST_SDR;
               w_timeout    = 1'b1;
               w_hdr_exit   = 1'b1;
            end
         end
         ST_EXIT: begin
            if (w_stop) begin
               w_next_state = ST_SDR;
               w_hdr_exit   = 1'b1;
            end else if (w_idle_to) begin
               w_next_state = ST_SDR;
               w_timeout    = 1'b1;
               w_hdr_exit   = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_SDR;
         end
      endcase
   end

   // Outputs decode the next state so they are registered with 1-cycle latency
   always_comb begin
      w_sdr_en = 1'b0;
      w_ddr_en = 1'b0;
      w_mode   = 2'd0;
      case (w_next_state)
         ST_SDR: begin
            w_sdr_en = 1'b1;
            w_mode   = 2'd0;
         end
         ST_ENTRY: begin
            w_mode = 2'd1;
         end
         ST_ACTIVE, ST_RESTART: begin
            w_ddr_en = 1'b1;
            w_mode   = 2'd2;
         end
         default: begin
            w_mode = 2'd3;
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         r_sdr_en    <= 1'b1;
         r_ddr_en    <= 1'b0;
         r_mode      <= 2'd0;
         r_ddr_rearm <= 1'b0;
         r_hdr_exit  <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_sdr_en    <= w_sdr_en;
         r_ddr_en    <= w_ddr_en;
         r_mode      <= w_mode;
         r_ddr_rearm <= w_ddr_rearm;
         r_hdr_exit  <= w_hdr_exit;
         r_timeout   <= w_timeout;
      end
   end

   assign o_sdr_en    = r_sdr_en;
   assign o_ddr_en    = r_ddr_en;
   assign o_mode      = r_mode;
   assign o_ddr_rearm = r_ddr_rearm;
   assign o_hdr_exit  = r_hdr_exit;
   assign o_timeout   = r_timeout;

`ifdef HDR_FRAME_COUNT_EN
   logic [7:0] r_frame_cnt;

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         r_frame_cnt <= 8'd0;
      end else if ((r_state == ST_SDR) && (w_next_state == ST_ENTRY)) begin
         r_frame_cnt <= 8'd0;
      end else if ((w_next_state == ST_RESTART) && (r_state != ST_RESTART)
                   && (r_frame_cnt != 8'hFF)) begin
         r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
`else
   assign o_frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hdr_mode_controller.sv
// tb/tb_hdr_mode_controller.sv - self-checking bench for hdr_mode_controller

module tb_hdr_mode_controller;

   // input vector {enthdr, restart, exit, error, scl, sda}
   localparam logic [5:0] I_IDLE = 6'b000011;
   localparam logic [5:0] I_EN   = 6'b100011;
   localparam logic [5:0] I_RS   = 6'b010011;
   localparam logic [5:0] I_EX   = 6'b001011;
   localparam logic [5:0] I_ER   = 6'b000111;
   localparam logic [5:0] I_S0   = 6'b000010;
   localparam logic [5:0] I_L0   = 6'b000000;
   localparam logic [5:0] I_L1   = 6'b000001;

   // expected {sdr_en, ddr_en, mode[1:0], rearm, hdr_exit, timeout}
   localparam logic [6:0] E_SDR  = 7'b1000000;
   localparam logic [6:0] E_SDRX = 7'b1000010;
   localparam logic [6:0] E_ENT  = 7'b0001000;
   localparam logic [6:0] E_ACTR = 7'b0110100;
   localparam logic [6:0] E_ACT  = 7'b0110000;
   localparam logic [6:0] E_M3   = 7'b0011000;

`ifdef HDR_FRAME_COUNT_EN
   localparam logic [7:0] FC_A = 8'd3;
`else
   localparam logic [7:0] FC_A = 8'd0;
`endif

   typedef struct {
      logic [5:0] vin;
      logic [6:0] vexp;
      logic       fc_chk;
      logic [7:0] fc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda = 1'b1;
   logic       en = 1'b0;
   logic       rs = 1'b0;
   logic       ex = 1'b0;
   logic       er = 1'b0;
   logic       sdr_en;
   logic       ddr_en;
   logic [1:0] mode;
   logic       rearm;
   logic       hexit;
   logic       tmo;
   logic [7:0] fcnt;

   int         total = 0;
   int         bad = 0;
   vec_t       vecs[$];
   logic [6:0] sb_q[$];

   hdr_mode_controller dut (
      .i_sys_clk     (clk),
      .i_sys_rst     (rst_n),
      .i_scl         (scl),
      .i_sda         (sda),
      .i_enthdr_ddr  (en),
      .i_restart_det (rs),
      .i_exit_det    (ex),
      .i_ddr_error   (er),
      .o_sdr_en      (sdr_en),
      .o_ddr_en      (ddr_en),
      .o_mode        (mode),
      .o_ddr_rearm   (rearm),
      .o_hdr_exit    (hexit),
      .o_timeout     (tmo),
      .o_frame_cnt   (fcnt)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {sdr_en, ddr_en, mode, rearm, hexit, tmo};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic void add(input logic [5:0] vin, input logic [6:0] vexp);
      vec_t v;
      v.vin = vin;
      v.vexp = vexp;
      v.fc_chk = 1'b0;
      v.fc = 8'd0;
      vecs.push_back(v);
   endfunction

   function automatic void add_fc(input logic [7:0] fc);
      vecs[vecs.size()-1].fc_chk = 1'b1;
      vecs[vecs.size()-1].fc = fc;
   endfunction

   task automatic apply(input logic [5:0] vin, input logic [6:0] vexp, input string nm);
      logic [6:0] e;
      @(negedge clk);
      {en, rs, ex, er, scl, sda} = vin;
      sb_q.push_back(vexp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk(nm, {25'd0, outs()}, {25'd0, e});
      end
   endtask

   task automatic enter_active(input string nm);
      apply(I_EN, E_ENT, {nm, "_en"});
      for (int k = 0; k < 3; k++) apply(I_IDLE, E_ENT, {nm, "_ent"});
      apply(I_IDLE, E_ACTR, {nm, "_act"});
   endtask

   // the two engine enables must never overlap
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if (sdr_en && ddr_en) begin
            bad++;
            $display("FAIL both_en: sdr_en=%0b ddr_en=%0b required not both 1", sdr_en, ddr_en);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;

      // entry, three restarts (one dropped back-to-back), exit with STOP
      add(I_EN, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT);
      add(I_IDLE, E_ACTR); add(I_IDLE, E_ACT);
      add(I_RS, E_ACTR); add(I_RS, E_ACT); add(I_IDLE, E_ACT);
      add(I_RS, E_ACTR); add(I_IDLE, E_ACT); add(I_IDLE, E_ACT);
      add(I_RS, E_ACTR); add(I_IDLE, E_ACT);
      add(I_EX, E_M3); add(I_S0, E_M3); add(I_L0, E_M3); add(I_L1, E_M3);
      add(I_IDLE, E_M3); add(I_S0, E_M3); add(I_IDLE, E_SDRX);
      add(I_IDLE, E_SDR); add_fc(FC_A);
      add(I_RS | I_EX, E_SDR);
      // error: restart ignored, STOP ignored, exit+STOP returns to SDR
      add(I_EN, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT);
      add(I_IDLE, E_ACTR); add(I_ER, E_M3); add(I_RS, E_M3); add(I_ER | I_RS, E_M3);
      add(I_S0, E_M3); add(I_IDLE, E_M3); add(I_EX, E_M3); add(I_S0, E_M3);
      add(I_IDLE, E_SDRX); add(I_IDLE, E_SDR);
      // priorities: enthdr in SDR, exit during entry, error over restart, exit over all
      add(I_EN | I_RS | I_EX, E_ENT); add(I_EX, E_M3); add(I_S0, E_M3); add(I_IDLE, E_SDRX);
      add(I_EN, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT);
      add(I_IDLE, E_ACTR); add(I_ER | I_RS, E_M3); add(I_S0, E_M3); add(I_IDLE, E_M3);
      add(I_EX, E_M3); add(I_S0, E_M3); add(I_IDLE, E_SDRX);
      add(I_EN, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT);
      add(I_IDLE, E_ACTR); add(I_EX | I_RS, E_M3); add(I_S0, E_M3); add(I_IDLE, E_SDRX);
      add(I_EN, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT); add(I_IDLE, E_ENT);
      add(I_IDLE, E_ACTR); add(I_EX | I_ER | I_RS, E_M3); add(I_S0, E_M3);
      add(I_IDLE, E_SDRX); add_fc(8'd0);

      // reset state, both during and after reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hold", {25'd0, outs()}, {25'd0, E_SDR});
      chk("reset_fcnt", {24'd0, fcnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_release", {25'd0, outs()}, {25'd0, E_SDR});

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].vin, vecs[i].vexp, $sformatf("vec%0d", i));
         if (vecs[i].fc_chk) chk($sformatf("fcnt%0d", i), {24'd0, fcnt}, {24'd0, vecs[i].fc});
      end

      // idle timeout: SCL activity keeps HDR alive, then static SCL forces SDR
      enter_active("to");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         scl = ~scl;
         repeat (700) @(posedge clk);
         #1;
         chk($sformatf("keepalive%0d", k), {29'd0, mode, ddr_en}, {29'd0, 2'd2, 1'b1});
      end
      @(negedge clk);
      scl = ~scl;
      @(posedge clk);
      #1;
      n = 0;
      while (mode != 2'd0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (n < 1024 || n > 1026) begin
         bad++;
         $display("FAIL timeout_cycles: got %0d cycles required 1024..1026", n);
      end
      chk("timeout_exit", {25'd0, outs()}, {25'd0, 7'b1000011});
      @(posedge clk);
      #1;
      chk("timeout_sticky", {25'd0, outs()}, {25'd0, 7'b1000001});
      enter_active("clr");

      // asynchronous reset in the middle of a restart
      apply(I_RS, E_ACTR, "pre_rst");
      @(negedge clk);
      {en, rs, ex, er, scl, sda} = I_IDLE;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {25'd0, outs()}, {25'd0, E_SDR});
      chk("async_rst_fcnt", {24'd0, fcnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst", {25'd0, outs()}, {25'd0, E_SDR});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hdr_mode_controller.md
Name: hdr_mode_controller

Overview:
- Target-side mode sequencer sitting directly downstream of the HDR restart detector.
- Consumes the restart pulse, the HDR exit-pattern pulse and the ENTHDR0 CCC decode from the SDR engine.
- Decides which engine (SDR or HDR-DDR) owns the bus, and re-arms the DDR engine on every HDR restart.
- Returns the target to SDR after an HDR exit followed by a STOP, or after a bus-idle timeout.

Parameters:
- ENTRY_DLY, 4, sys-clk cycles held in HDR_ENTRY before enabling the DDR engine (range 1..15).
- IDLE_TIMEOUT, 1024, sys-clk cycles without any SCL edge in HDR_ACTIVE/HDR_ERROR/HDR_EXIT before forced return to SDR.
- CNT_W, 11, width of the idle counter; must satisfy 2^CNT_W > IDLE_TIMEOUT.

Ports:
- i_sys_clk  input  1  system clock; all logic on rising edge.
- i_sys_rst  input  1  asynchronous, active-low reset.
- i_scl  input  1  bus SCL, already sampled in the i_sys_clk domain.
- i_sda  input  1  bus SDA, already sampled in the i_sys_clk domain.
- i_enthdr_ddr  input  1  one-cycle pulse from the SDR engine: ENTHDR0 broadcast CCC received.
- i_restart_det  input  1  one-cycle pulse from the restart detector: HDR restart pattern seen.
- i_exit_det  input  1  one-cycle pulse: HDR exit pattern seen.
- i_ddr_error  input  1  level/pulse from the DDR engine: framing or parity error.
- o_sdr_en  output  1  SDR engine enable.
- o_ddr_en  output  1  DDR engine enable.
- o_mode  output  2  mode code: 0 = SDR, 1 = HDR_ENTRY, 2 = HDR_ACTIVE (includes RESTART), 3 = HDR_ERROR/EXIT.
- o_ddr_rearm  output  1  one-cycle pulse telling the DDR engine to reset its frame state.
- o_hdr_exit  output  1  one-cycle pulse on return to SDR.
- o_timeout  output  1  sticky flag; set on idle timeout, cleared by the next i_enthdr_ddr.
- o_frame_cnt  output  8  restart count within the current HDR session (optional feature).

Behaviour:
- Reset (asynchronous, i_sys_rst = 0):
  - state = SDR, o_sdr_en = 1, o_ddr_en = 0, o_mode = 0.
  - o_ddr_rearm = 0, o_hdr_exit = 0, o_timeout = 0, o_frame_cnt = 0.
  - Idle counter = 0, SCL/SDA history registers = 1.
  - Reset mid-operation aborts any state immediately; there is no partial pulse.
- All outputs are registered. Input-to-output latency is 1 cycle.
- SCL edge detect: scl_q <= i_scl; edge = i_scl ^ scl_q. STOP = (i_scl & scl_q & i_sda & ~sda_q).
- Idle counter:
  - Clears on every SCL edge and on every state change; otherwise increments.
  - Saturates at IDLE_TIMEOUT.
- States and transitions:
  - SDR:
    - o_sdr_en = 1, o_ddr_en = 0.
    - i_enthdr_ddr -> HDR_ENTRY, clear o_timeout, load entry count.
    - i_restart_det and i_exit_det are ignored.
  - HDR_ENTRY:
    - o_sdr_en = 0, o_ddr_en = 0.
    - Count ENTRY_DLY cycles, then go to HDR_ACTIVE and pulse o_ddr_rearm on the entry cycle.
    - i_exit_det during entry -> HDR_EXIT.
  - HDR_ACTIVE:
    - o_ddr_en = 1.
    - Priority: i_exit_det > i_ddr_error > i_restart_det > timeout.
    - i_exit_det -> HDR_EXIT.
    - i_ddr_error -> HDR_ERROR.
    - i_restart_det -> HDR_RESTART.
    - Idle counter == IDLE_TIMEOUT -> SDR, set o_timeout, pulse o_hdr_exit.
  - HDR_RESTART:
    - Lasts exactly one cycle; o_ddr_rearm = 1, o_ddr_en stays 1.
    - Returns to HDR_ACTIVE.
    - A restart pulse arriving in this cycle is dropped.
  - HDR_ERROR:
    - o_ddr_en = 0; the target ignores the bus.
    - Only i_exit_det (-> HDR_EXIT) or timeout (-> SDR, o_timeout = 1) leaves this state.
    - i_restart_det is ignored.
  - HDR_EXIT:
    - o_ddr_en = 0, o_sdr_en = 0.
    - STOP -> SDR with o_hdr_exit pulsed on the transition cycle.
    - Timeout -> SDR with o_timeout = 1.
- Simultaneous i_enthdr_ddr and any HDR pulse in SDR: enthdr wins.
- o_sdr_en and o_ddr_en are never both 1.

Optional Feature:
- Macro: HDR_FRAME_COUNT_EN.
- Defined:
  - o_frame_cnt clears to 0 on the SDR->HDR_ENTRY transition.
  - Increments by 1 on every HDR_RESTART entry, saturating at 255.
  - Holds its value in SDR until the next entry.
- Undefined: o_frame_cnt is tied to 0 and no counter flops exist.

Test Plan:
1. Reset low, then high -> o_sdr_en = 1, o_ddr_en = 0, o_mode = 0, all pulses 0.
2. Entry: i_enthdr_ddr pulse -> o_mode = 1 for 4 cycles, then o_ddr_en = 1, o_mode = 2, o_ddr_rearm high for 1 cycle.
3. Restarts in HDR_ACTIVE:
   - 3 spaced i_restart_det pulses -> 3 single-cycle o_ddr_rearm pulses.
   - o_frame_cnt = 3 with HDR_FRAME_COUNT_EN.
4. Exit: i_exit_det, then SDA 0->1 with SCL held 1 -> o_hdr_exit pulse 1 cycle after STOP, o_sdr_en = 1, o_mode = 0.
5. Error: i_ddr_error, then i_restart_det -> o_ddr_en = 0, no rearm. Then i_exit_det plus STOP -> SDR.
6. Timeout: in HDR_ACTIVE hold SCL static for 1024 cycles -> SDR, o_timeout = 1. Next i_enthdr_ddr clears o_timeout. Same-cycle i_exit_det and i_restart_det -> HDR_EXIT, no rearm.
